// File: rtl/ad_pkg.sv
// Shared constants and types for the AD conversion scheduler and its arbiter.
package ad_pkg;

  localparam int unsigned AD_NCH        = 8;
  localparam int unsigned AD_DW         = 16;
  localparam int unsigned AD_CHW        = $clog2(AD_NCH);
  localparam int unsigned AD_PERIOD_MIN = 2;

  typedef logic [AD_DW-1:0]  ad_sample_t;
  typedef logic [AD_CHW-1:0] ad_ch_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: combinational one-hot grant plus encoded index, searching upward from
// the last granted index + 1. The pointer resets to NCH-1 so channel 0 has first priority.
module rr_arb
  import ad_pkg::*;
#(
  parameter int unsigned NCH = AD_NCH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH-1:0]         req_i,
  input  logic                   advance_i,
  output logic [NCH-1:0]         gnt_o,
  output logic [$clog2(NCH)-1:0] idx_o
);

  localparam int unsigned CHW = $clog2(NCH);

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] cand;
  logic           found;

  // NCH is a power of two, so CHW-bit addition wraps modulo NCH.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = ptr_q + CHW'(k);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= CHW'(NCH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ad_sched.sv
// Conversion scheduler: periodic start pulses, one-deep per-channel capture with sticky
// overflow, and a round-robin serialiser onto a channel-tagged valid/ready stream.
module ad_sched
  import ad_pkg::*;
#(
  parameter int unsigned NCH = AD_NCH,
  parameter int unsigned DW  = AD_DW,
  parameter int unsigned PW  = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PW-1:0]          period,
  input  logic [NCH-1:0]         ch_mask,
  output logic [NCH-1:0]         ad_start,
  input  logic [NCH*DW-1:0]      ad_data,
  input  logic [NCH-1:0]         ad_vld,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [NCH-1:0]         ovf,
  input  logic                   ovf_clr
);

  localparam int unsigned CHW = $clog2(NCH);

  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [PW-1:0]  pmax, pterm;
  logic [NCH-1:0] start_q, start_d;
  logic [NCH-1:0] full_q, full_d;
  logic [NCH-1:0] ovf_q, ovf_d, ovf_set;
  logic [DW-1:0]  hold_q [NCH];
  logic [DW-1:0]  hold_d [NCH];
  logic [DW-1:0]  odata_q, odata_d;
  logic [CHW-1:0] och_q, och_d;
  logic           ovld_q, ovld_d;
  logic           load, advance;
  logic [NCH-1:0] gnt, drain;
  logic [CHW-1:0] gidx;

  always_comb begin
    pmax    = (period < PW'(AD_PERIOD_MIN)) ? PW'(AD_PERIOD_MIN) : period;
    pterm   = pmax - PW'(1);
    pcnt_d  = '0;
    start_d = '0;
    if (en) begin
      if (pcnt_q == pterm) begin
        start_d = ch_mask;
      end
      // A period shortened below the current count wraps without a pulse.
      pcnt_d = (pcnt_q >= pterm) ? '0 : pcnt_q + PW'(1);
    end
  end

  assign load    = !ovld_q || out_rdy;
  assign advance = load && (|full_q);
  assign drain   = gnt & {NCH{load}};

  rr_arb #(
    .NCH(NCH)
  ) u_rr_arb (
    .clk_i    (clk_sys),
    .rst_i    (rst),
    .req_i    (full_q),
    .advance_i(advance),
    .gnt_o    (gnt),
    .idx_o    (gidx)
  );

  // A channel being drained this cycle can accept a new sample without overflowing.
  always_comb begin
    full_d  = full_q;
    hold_d  = hold_q;
    ovf_set = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ad_vld[i] && ch_mask[i]) begin
        if (!full_q[i] || drain[i]) begin
          hold_d[i] = ad_data[i*DW +: DW];
          full_d[i] = 1'b1;
        end else begin
          ovf_set[i] = 1'b1;
        end
      end else if (drain[i]) begin
        full_d[i] = 1'b0;
      end
    end
    ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  always_comb begin
    odata_d = odata_q;
    och_d   = och_q;
    ovld_d  = ovld_q;
    if (load) begin
      ovld_d = |full_q;
      if (|full_q) begin
        odata_d = hold_q[gidx];
        och_d   = gidx;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pcnt_q  <= '0;
      start_q <= '0;
      full_q  <= '0;
      hold_q  <= '{default: '0};
      ovf_q   <= '0;
      odata_q <= '0;
      och_q   <= '0;
      ovld_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      start_q <= start_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      odata_q <= odata_d;
      och_q   <= och_d;
      ovld_q  <= ovld_d;
    end
  end

  assign ad_start = start_q;
  assign out_data = odata_q;
  assign out_ch   = och_q;
  assign out_vld  = ovld_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ad_sched.sv
// Bench for ad_sched: directed scenarios plus a randomized phase, checked every cycle against
// a behavioural model of pulse timing, capture slots, overflow and round-robin draining.
module tb_ad_sched;

  logic         clk_sys = 1'b0;
  logic         rst;
  logic         en;
  logic [15:0]  period;
  logic [7:0]   ch_mask;
  logic [7:0]   ad_start;
  logic [127:0] ad_data;
  logic [7:0]   ad_vld;
  logic [15:0]  out_data;
  logic [2:0]   out_ch;
  logic         out_vld;
  logic         out_rdy;
  logic [7:0]   ovf;
  logic         ovf_clr;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int pticks[$];
  logic [18:0] beats[$];

  // Reference model state
  int          m_en_cyc;
  logic [7:0]  m_start;
  bit          m_full[8];
  logic [15:0] m_hold[8];
  logic [7:0]  m_ovf;
  int          m_ptr;
  logic        m_ovld;
  logic [15:0] m_odata;
  int          m_och;

  ad_sched #(
    .NCH(8),
    .DW (16),
    .PW (16)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .en      (en),
    .period  (period),
    .ch_mask (ch_mask),
    .ad_start(ad_start),
    .ad_data (ad_data),
    .ad_vld  (ad_vld),
    .out_data(out_data),
    .out_ch  (out_ch),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en_cyc = 0;
    m_start  = 8'h00;
    m_ovf    = 8'h00;
    m_ptr    = 7;
    m_ovld   = 1'b0;
    m_odata  = 16'h0000;
    m_och    = 0;
    for (int i = 0; i < 8; i++) begin
      m_full[i] = 1'b0;
      m_hold[i] = 16'h0000;
    end
  endtask

  // Advances the model by one clock using the inputs presented before the edge.
  task automatic model_step();
    int pm;
    int g;
    int n;
    bit load;
    pm = (period < 16'd2) ? 2 : int'(period);
    // Pulse on every pm-th enabled cycle since enable (period is only changed while en=0).
    if (en) begin
      n = m_en_cyc + 1;
      m_en_cyc = n;
      m_start = (n % pm == 0) ? ch_mask : 8'h00;
    end else begin
      m_en_cyc = 0;
      m_start = 8'h00;
    end
    load = !m_ovld || out_rdy;
    g = -1;
    if (load) begin
      for (int k = 1; k <= 8; k++) begin
        if (g < 0 && m_full[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
      end
      if (g >= 0) begin
        m_odata = m_hold[g];
        m_och   = g;
        m_ovld  = 1'b1;
        m_ptr   = g;
      end else begin
        m_ovld = 1'b0;
      end
    end
    if (ovf_clr) m_ovf = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (ad_vld[i] && ch_mask[i]) begin
        if (!m_full[i] || g == i) begin
          m_hold[i] = ad_data[i*16 +: 16];
          m_full[i] = 1'b1;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end else if (g == i) begin
        m_full[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("ad_start", 32'(ad_start), 32'(m_start));
    check("out_vld", 32'(out_vld), 32'(m_ovld));
    check("out_data", 32'(out_data), 32'(m_odata));
    check("out_ch", 32'(out_ch), 32'(m_och));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic tick();
    if (out_vld && out_rdy) beats.push_back({out_ch, out_data});
    model_step();
    @(posedge clk_sys);
    #1;
    tick_no++;
    compare_all();
    if (ad_start != 8'h00) pticks.push_back(tick_no);
  endtask

  task automatic set_ch(input int ch, input logic [15:0] v);
    ad_data[ch*16 +: 16] = v;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; period = 16'd10; ch_mask = 8'hFF; ad_vld = 8'h00;
    ad_data = '0; out_rdy = 1'b1; ovf_clr = 1'b0;
    model_reset();
    #12;
    check("rst_ad_start", 32'(ad_start), 32'h0);
    check("rst_out_vld", 32'(out_vld), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;

    // Period 10: pulses in cycles 10, 20, 30 after enable.
    tick_no = 0; pticks.delete();
    en = 1'b1;
    repeat (35) tick();
    check("p10_npulse", 32'(pticks.size()), 32'd3);
    if (pticks.size() == 3) begin
      check("p10_first", 32'(pticks[0]), 32'd10);
      check("p10_second", 32'(pticks[1]), 32'd20);
      check("p10_third", 32'(pticks[2]), 32'd30);
    end
    en = 1'b0; pticks.delete();
    repeat (20) tick();
    check("en0_npulse", 32'(pticks.size()), 32'd0);

    // Eight simultaneous samples drain 0..7 back to back, first beat two cycles later.
    beats.delete();
    for (int i = 0; i < 8; i++) set_ch(i, 16'h1000 + 16'(i));
    ad_vld = 8'hFF;
    tick();
    ad_vld = 8'h00;
    check("all8_lat1", 32'(out_vld), 32'h0);
    tick();
    check("all8_lat2", 32'(out_vld), 32'h1);
    repeat (9) tick();
    check("all8_nbeats", 32'(beats.size()), 32'd8);
    if (beats.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check("all8_ch", 32'(beats[k][18:16]), 32'(k));
        check("all8_data", 32'(beats[k][15:0]), 32'h1000 + 32'(k));
      end
    end

    // Stall with out_vld=1, double pulse on ch3.
    out_rdy = 1'b0;
    set_ch(0, 16'hAAAA); ad_vld = 8'h01; tick();
    ad_vld = 8'h00; tick();
    set_ch(3, 16'h3333); ad_vld = 8'h08; tick();
    ad_vld = 8'h00; tick();
    set_ch(3, 16'h4444); ad_vld = 8'h08; tick();
    ad_vld = 8'h00;
    check("stall_ch", 32'(out_ch), 32'h0);
    check("stall_data", 32'(out_data), 32'hAAAA);
    check("stall_ovf3", 32'(ovf[3]), 32'h1);
    beats.delete();
    out_rdy = 1'b1;
    repeat (3) tick();
    check("stall_nbeats", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) check("stall_kept", 32'(beats[1]), {13'h0, 3'd3, 16'h3333});

    // Ch5 drained in the same cycle its new sample arrives.
    beats.delete();
    set_ch(5, 16'h5550); ad_vld = 8'h20; tick();
    set_ch(5, 16'h5551); ad_vld = 8'h20; tick();
    ad_vld = 8'h00;
    repeat (3) tick();
    check("ch5_ovf", 32'(ovf[5]), 32'h0);
    check("ch5_nbeats", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) begin
      check("ch5_beat0", 32'(beats[0]), {13'h0, 3'd5, 16'h5550});
      check("ch5_beat1", 32'(beats[1]), {13'h0, 3'd5, 16'h5551});
    end

    // Periods 0 and 1 behave as 2.
    period = 16'd0; en = 1'b1; tick_no = 0; pticks.delete();
    repeat (8) tick();
    check("p0_npulse", 32'(pticks.size()), 32'd4);
    if (pticks.size() > 0) check("p0_first", 32'(pticks[0]), 32'd2);
    en = 1'b0; tick();
    period = 16'd1; en = 1'b1; tick_no = 0; pticks.delete();
    repeat (8) tick();
    check("p1_npulse", 32'(pticks.size()), 32'd4);
    if (pticks.size() > 0) check("p1_first", 32'(pticks[0]), 32'd2);
    en = 1'b0; tick();

    // ovf_clr coinciding with a new overflow on ch6.
    out_rdy = 1'b0;
    set_ch(6, 16'h6660); ad_vld = 8'h40; tick();
    ad_vld = 8'h00; tick();
    set_ch(6, 16'h6661); ad_vld = 8'h40; tick();
    set_ch(6, 16'h6662); ad_vld = 8'h40; ovf_clr = 1'b1; tick();
    ad_vld = 8'h00;
    check("clr_set_wins", 32'(ovf), 32'h40);
    tick();
    ovf_clr = 1'b0;
    check("clr_alone", 32'(ovf), 32'h0);
    out_rdy = 1'b1;
    repeat (4) tick();

    // Randomized traffic.
    period = 16'($urandom_range(0, 12));
    en = 1'b1;
    repeat (400) begin
      ch_mask = 8'($urandom);
      ad_vld  = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < 8; i++) set_ch(i, 16'($urandom));
      out_rdy = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    en = 1'b0; ad_vld = 8'h00; ch_mask = 8'hFF; out_rdy = 1'b1; ovf_clr = 1'b0;
    repeat (12) tick();

    // Asynchronous reset mid-transfer, with the pointer left at ch3.
    out_rdy = 1'b0;
    set_ch(3, 16'hC003); ad_vld = 8'h08; tick();
    ad_vld = 8'h00; tick();
    set_ch(1, 16'hC001); set_ch(6, 16'hC006); ad_vld = 8'h42; tick();
    ad_vld = 8'h00;
    check("pre_rst_vld", 32'(out_vld), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ad_start", 32'(ad_start), 32'h0);
    check("mid_rst_out_vld", 32'(out_vld), 32'h0);
    check("mid_rst_out_data", 32'(out_data), 32'h0);
    check("mid_rst_out_ch", 32'(out_ch), 32'h0);
    check("mid_rst_ovf", 32'(ovf), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    set_ch(0, 16'h0A00); set_ch(5, 16'h0A05); ad_vld = 8'h21; tick();
    ad_vld = 8'h00; tick();
    check("post_rst_ch", 32'(out_ch), 32'h0);
    check("post_rst_data", 32'(out_data), 32'h0A00);
    tick();
    check("post_rst_ch2", 32'(out_ch), 32'h5);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
